// File: rtl/cpu_ext_bus_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cpu_ext_bus_bridge
// Purpose  : Splits one DATA_W-bit CPU read/write request into sequential
//            little-endian byte cycles on an 8-bit external bus. Each byte
//            cycle has programmable wait states and waits for a slave ack,
//            with a timeout. Returns the assembled read data with a one-cycle
//            ready pulse, plus an error flag when a byte cycle times out.
// Ports    : i_clk, i_rst      - clock, synchronous active-high reset
//            i_cpu_*           - CPU request (level req, we, addr, wdata)
//            o_cpu_rdata/ready/err - completion (ready and err are pulses)
//            o_ext_cs/we/addr/wdata - external byte-cycle strobe and payload
//            i_ext_rdata/ack   - slave read byte and ready
// Revision : 1.0 - initial release
// ============================================================================
module cpu_ext_bus_bridge #(
  parameter int DATA_W      = 32,
  parameter int EXT_ADDR_W  = 24,
  parameter int WAIT_CYCLES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [DATA_W-1:0]     i_cpu_addr,
  input  logic [DATA_W-1:0]     i_cpu_wdata,
  output logic [DATA_W-1:0]     o_cpu_rdata,
  output logic                  o_cpu_ready,
  output logic                  o_cpu_err,
  output logic                  o_ext_cs,
  output logic                  o_ext_we,
  output logic [EXT_ADDR_W-1:0] o_ext_addr,
  output logic [7:0]            o_ext_wdata,
  input  logic [7:0]            i_ext_rdata,
  input  logic                  i_ext_ack
);

  localparam int N      = DATA_W / 8;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_CYCLES);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STROBE  = 3'd1,
    S_WAITACK = 3'd2,
    S_GAP     = 3'd3,
    S_DONE    = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [EXT_ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic [TCNT_W-1:0]       tcnt_q, tcnt_d;
  logic                    err_q, err_d;

  logic                    w_byte_done;
  logic                    w_abort;
  logic [IDX_W+2:0]        w_bit_sel;

  // Bit offset of the current byte lane inside the CPU word.
  assign w_bit_sel = {idx_q, 3'b000};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    tcnt_d      = tcnt_q;
    err_d       = err_q;
    w_byte_done = 1'b0;
    w_abort     = 1'b0;
    o_ext_cs    = 1'b0;
    o_cpu_ready = 1'b0;
    o_cpu_err   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_cpu_req) begin
          we_d    = i_cpu_we;
          addr_d  = i_cpu_addr[EXT_ADDR_W-1:0];
          wdata_d = i_cpu_wdata;
          rdata_d = '0;
          idx_d   = '0;
          wcnt_d  = '0;
          tcnt_d  = '0;
          err_d   = 1'b0;
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        o_ext_cs = 1'b1;
        // Ack is only honoured on the final minimum-width strobe cycle.
        if (wcnt_q == WCNT_LAST) begin
          if (i_ext_ack) begin
            w_byte_done = 1'b1;
          end else if (TIMEOUT == 0) begin
            w_abort = 1'b1;
          end else begin
            tcnt_d  = '0;
            state_d = S_WAITACK;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_WAITACK: begin
        o_ext_cs = 1'b1;
        if (i_ext_ack) begin
          w_byte_done = 1'b1;
        end else if (tcnt_q == TCNT_LAST) begin
          w_abort = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_GAP: begin
        wcnt_d  = '0;
        state_d = S_STROBE;
      end
      S_DONE: begin
        o_cpu_ready = 1'b1;
        o_cpu_err   = err_q;
        state_d     = S_DRAIN;
      end
      S_DRAIN: begin
        // A request level held across completion must not start a new one.
        if (!i_cpu_req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_byte_done) begin
      if (!we_q) begin
        rdata_d[w_bit_sel +: 8] = i_ext_rdata;
      end
      if (idx_q == IDX_LAST) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_GAP;
      end
    end

    if (w_abort) begin
      err_d   = 1'b1;
      state_d = S_DONE;
      // Bytes that never arrived (including the one that timed out) read as FF.
      if (!we_q) begin
        for (int i = 0; i < N; i++) begin
          if (i >= int'(idx_q)) begin
            rdata_d[8*i +: 8] = 8'hFF;
          end
        end
      end
    end
  end

  assign o_ext_we    = o_ext_cs & we_q;
  assign o_ext_addr  = o_ext_cs ? (addr_q + EXT_ADDR_W'(idx_q)) : '0;
  assign o_ext_wdata = o_ext_cs ? wdata_q[w_bit_sel +: 8] : 8'h00;
  assign o_cpu_rdata = rdata_q;

endmodule
`default_nettype wire
